// File: rtl/booth_job_sequencer_pkg.sv
// Shared definitions for the Booth multiplier job sequencer and its datapath:
// state encoding and the default operand width / timeout.
package booth_job_sequencer_pkg;

  localparam int BOOTH_N       = 8;
  localparam int BOOTH_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_DELIVER = 3'd4,
    ST_RECOVER = 3'd5
  } seq_state_t;

endpackage

// File: rtl/booth_result_reg.sv
// Output holding register with valid/ready; a load is legal when empty or
// when the current contents are drained in the same cycle.
module booth_result_reg #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         can_load,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  assign can_load  = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/booth_job_sequencer.sv
// Job sequencer around the Booth multiplier: accepts operand pairs, launches
// the multiplier, captures its product (or a timeout) and returns it to idle.
module booth_job_sequencer
  import booth_job_sequencer_pkg::*;
#(
  parameter int N           = BOOTH_N,
  parameter int CAPTURE_LAT = 1,
  parameter int TIMEOUT     = BOOTH_TIMEOUT,
  parameter int TW          = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_m,
  input  logic [N-1:0]   in_q,
  output logic           mul_start,
  output logic [N-1:0]   mul_data_m,
  output logic [N-1:0]   mul_data_q,
  output logic           mul_restart,
  input  logic           mul_done,
  input  logic [2*N-1:0] mul_ans,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_prod,
  output logic           out_err,
  output logic           busy
);

  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TCNT_MAX     = {TW{1'b1}};
  localparam logic [1:0]    SETTLE_LAST  = (CAPTURE_LAT > 0) ? 2'(CAPTURE_LAT - 1) : 2'd0;

  seq_state_t    state_reg;
  logic          in_ready_reg;
  logic          mul_start_reg;
  logic          mul_restart_reg;
  logic [N-1:0]  data_m_reg;
  logic [N-1:0]  data_q_reg;
  logic [TW-1:0] tcnt_reg;
  logic [1:0]    scnt_reg;
  logic          launch_cnt_reg;
  logic          err_reg;

  logic           res_can_load;
  logic           res_load;
  logic [2*N:0]   res_data;
  logic [2*N:0]   res_q;

  assign in_ready    = in_ready_reg;
  assign mul_start   = mul_start_reg;
  assign mul_restart = mul_restart_reg;
  assign mul_data_m  = data_m_reg;
  assign mul_data_q  = data_q_reg;
  assign busy        = (state_reg != ST_IDLE);

  // mul_ans is re-sampled on the actual load cycle; it is stable while done.
  assign res_load = (state_reg == ST_DELIVER) && res_can_load;
  assign res_data = {err_reg, err_reg ? {2*N{1'b0}} : mul_ans};
  assign out_err  = res_q[2*N];
  assign out_prod = res_q[2*N-1:0];

  booth_result_reg #(.W(2*N+1)) u_result (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (res_load),
    .load_data (res_data),
    .out_ready (out_ready),
    .can_load  (res_can_load),
    .out_valid (out_valid),
    .out_data  (res_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      in_ready_reg    <= 1'b1;
      mul_start_reg   <= 1'b0;
      mul_restart_reg <= 1'b0;
      data_m_reg      <= '0;
      data_q_reg      <= '0;
      tcnt_reg        <= '0;
      scnt_reg        <= '0;
      launch_cnt_reg  <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid && in_ready_reg) begin
            data_m_reg     <= in_m;
            data_q_reg     <= in_q;
            in_ready_reg   <= 1'b0;
            mul_start_reg  <= 1'b1;
            launch_cnt_reg <= 1'b0;
            state_reg      <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          // Start is held over the multiplier's idle and load states.
          if (launch_cnt_reg) begin
            mul_start_reg <= 1'b0;
            tcnt_reg      <= '0;
            state_reg     <= ST_WAIT;
          end else begin
            launch_cnt_reg <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (tcnt_reg != TCNT_MAX) tcnt_reg <= tcnt_reg + 1'b1;
          if (mul_done) begin
            scnt_reg  <= '0;
            state_reg <= (CAPTURE_LAT == 0) ? ST_DELIVER : ST_SETTLE;
          end else if (tcnt_reg == TIMEOUT_LAST) begin
            err_reg   <= 1'b1;
            state_reg <= ST_DELIVER;
          end
        end
        ST_SETTLE: begin
          if (scnt_reg == SETTLE_LAST) state_reg <= ST_DELIVER;
          else                         scnt_reg  <= scnt_reg + 2'd1;
        end
        ST_DELIVER: begin
          if (res_can_load) begin
            err_reg         <= 1'b0;
            mul_restart_reg <= 1'b1;
            state_reg       <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          mul_restart_reg <= 1'b0;
          in_ready_reg    <= 1'b1;
          state_reg       <= ST_IDLE;
        end
        default: begin
          mul_start_reg   <= 1'b0;
          mul_restart_reg <= 1'b0;
          in_ready_reg    <= 1'b1;
          state_reg       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/booth_job_sequencer.md
Name: booth_job_sequencer

Overview:
- Sits directly upstream and downstream of the Booth multiplier datapath/controlpath pair.
- Accepts signed operand pairs over a valid/ready handshake and drives the multiplier's start and operand inputs.
- Waits for the multiplier to finish, captures its 2N-bit product, and presents the result over a second valid/ready handshake.
- Recovers the multiplier to idle between jobs and flags jobs that never complete.

Parameters:
- N, 8, operand width in bits; the product is 2N bits.
- CAPTURE_LAT, 1, cycles between mul_done first seen high and mul_ans being valid (the multiplier's registered answer stage); range 0..3.
- TIMEOUT, 64, maximum cycles spent in WAIT before the job is declared failed; must be at least 2N+8.
- TW, 7, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair available.
- in_ready  out  1  sequencer can accept an operand pair.
- in_m  in  N  multiplicand, two's complement.
- in_q  in  N  multiplier, two's complement.
- mul_start  out  1  start request to the multiplier controlpath.
- mul_data_m  out  N  multiplicand to the multiplier.
- mul_data_q  out  N  multiplier operand to the multiplier.
- mul_restart  out  1  one-cycle pulse that returns the multiplier controller to its idle/clear state.
- mul_done  in  1  level; high while the multiplier sits in its finished state.
- mul_ans  in  2N  multiplier product {a,q}.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer accepts the result.
- out_prod  out  2N  captured product; forced to 0 on error.
- out_err  out  1  result was produced by a timeout, not by a completed multiply.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; in_ready=1; mul_start=0; mul_restart=0; mul_data_m=0; mul_data_q=0; out_valid=0; out_prod=0; out_err=0; busy=0; timeout and settle counters=0.
- Reset asserted mid-job discards the in-flight job and any unread result.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch in_m/in_q into mul_data_m/mul_data_q, then go to LAUNCH.
  - in_ready is 0 in every other state.
- State LAUNCH:
  - mul_start=1 for exactly 2 cycles. The multiplier samples start in its idle state, and the extra cycle covers its load state.
  - Operands stay stable from acceptance until the next acceptance.
  - Then go to WAIT with the timeout counter cleared.
- State WAIT:
  - The timeout counter increments each cycle.
  - If mul_done=1, go to SETTLE with the settle counter cleared.
  - Else, if the counter reaches TIMEOUT-1, set the internal err flag and go to DELIVER.
  - When mul_done and the timeout occur in the same cycle, mul_done wins.
- State SETTLE:
  - Stay for CAPTURE_LAT cycles (zero cycles when CAPTURE_LAT=0, i.e. pass straight through to DELIVER in the same transition), then go to DELIVER.
- State DELIVER:
  - Load the result register when it is empty, or when it is being drained in this same cycle (out_valid&&out_ready).
  - out_prod=mul_ans, or 0 if err; out_err=err; out_valid=1.
  - Otherwise stall in DELIVER, sampling mul_ans again on the load cycle. mul_ans is stable while the multiplier is in its finished state.
  - After loading, clear err and go to RECOVER.
- State RECOVER: mul_restart=1 for one cycle, then go to IDLE.
- Result register:
  - out_valid clears on out_valid&&out_ready unless reloaded in the same cycle.
  - out_prod/out_err are held stable while out_valid=1 and out_ready=0.
  - A new job may be accepted while the previous result is still unread; its capture stalls in DELIVER until space exists.
- Latency: from acceptance to out_valid=1 is 1 (LAUNCH entry) + 2 (LAUNCH) + t_done + CAPTURE_LAT + 1 cycles. t_done is the number of cycles in WAIT before mul_done is seen.
- Throughput: one job per (latency + 1) cycles at most.
- No arithmetic is performed on the product. The timeout counter saturates and never wraps inside WAIT.

Decomposition:
- Shared package holds:
  - the state enumeration (IDLE, LAUNCH, WAIT, SETTLE, DELIVER, RECOVER), 3-bit encoding;
  - the default N/TIMEOUT constants, common with the multiplier datapath.
- One natural sub-module, booth_result_reg: the 2N+1-bit output holding register with its valid/ready logic.

Test Plan:
- N=8, behavioural multiplier model (done after 20 cycles), in_m=3, in_q=-2 (8'hFE) -> one accepted job, mul_start high exactly 2 cycles, out_prod=16'hFFFA, out_err=0, then one mul_restart pulse.
- Back-to-back jobs (5×7, then -128×-128) with out_ready held 0 -> second job stalls in DELIVER; raising out_ready gives 16'h0023 then 16'h4000 in order, with no loss.
- Model never raises mul_done -> after TIMEOUT=64 cycles in WAIT: out_valid=1, out_err=1, out_prod=0, mul_restart pulse, in_ready=1 afterwards.
- mul_done rises on the same cycle the timeout count hits 63 -> out_err=0 and the real product is delivered.
- rst_n pulsed low during WAIT -> all outputs at reset values immediately (asynchronously); a new job afterwards completes normally.
- CAPTURE_LAT=0 and CAPTURE_LAT=3 builds -> product sampled exactly 0 and 3 cycles after mul_done; the model corrupts mul_ans before that window and the bench checks the correct value is captured.
